cpu7_wbpipe: RTL and testbench

CPU7_WBPIPE -- requirements
Module: cpu7_wbpipe

---
 rtl/cpu7_wbpipe.sv | 133 +++++++++++++
 tb/tb_cpu7_wbpipe.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cpu7_wbpipe.sv
// Post-EX result pipeline (MEM..WB) with operand forwarding, load-use stall and drain handshake.
// Optional: define CPU7_WBPIPE_FWD_EN to enable forwarding; otherwise any in-flight hazard stalls.
module cpu7_wbpipe #(
    parameter int XLEN     = 32,
    parameter int RFIDX_W  = 5,
    parameter int DEPTH    = 3,
    parameter int LD_STAGE = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    input  logic               ex_regwrite,
    input  logic [RFIDX_W-1:0] ex_rd,
    input  logic [XLEN-1:0]    ex_data,
    input  logic               ex_late,
    input  logic [XLEN-1:0]    late_data,
    input  logic [RFIDX_W-1:0] rs1idx,
    input  logic [RFIDX_W-1:0] rs2idx,
    input  logic               rs1_used,
    input  logic               rs2_used,
    input  logic [XLEN-1:0]    rs1_rf,
    input  logic [XLEN-1:0]    rs2_rf,
    output logic [XLEN-1:0]    rs1_val,
    output logic [XLEN-1:0]    rs2_val,
    output logic               stall,
    output logic               wb_en,
    output logic [RFIDX_W-1:0] wb_idx,
    output logic [XLEN-1:0]    wb_data,
    input  logic               empty_req,
    output logic               empty_ack
);

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic [RFIDX_W-1:0] rd;
        logic [XLEN-1:0]    data;
        logic               late;
    } stage_t;

    stage_t            st  [1:DEPTH];
    stage_t            nxt [1:DEPTH];
    logic [XLEN-1:0]   eff [1:DEPTH];

    logic [RFIDX_W-1:0] s_idx [2];
    logic [XLEN-1:0]    s_rf  [2];
    logic [XLEN-1:0]    s_fwd [2];
    logic               s_any [2];
    logic               s_hz  [2];
    logic               any_valid;
    logic               stall_c;

    // Only the load-data stage substitutes late_data for a pending late result.
    always_comb begin
        for (int k = 1; k <= DEPTH; k++) begin
            eff[k] = (k == LD_STAGE && st[k].late) ? late_data : st[k].data;
        end
    end

    assign s_idx[0] = rs1idx;
    assign s_idx[1] = rs2idx;
    assign s_rf[0]  = rs1_rf;
    assign s_rf[1]  = rs2_rf;

    // Scan oldest to youngest so the youngest (lowest-index) match wins.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            s_fwd[j] = s_rf[j];
            s_any[j] = 1'b0;
            s_hz[j]  = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (st[k].valid && st[k].regwrite && st[k].rd == s_idx[j] && s_idx[j] != '0) begin
                    s_fwd[j] = eff[k];
                    s_any[j] = 1'b1;
                    s_hz[j]  = (k < LD_STAGE) && st[k].late;
                end
            end
        end
    end

`ifdef CPU7_WBPIPE_FWD_EN
    assign stall_c = (rs1_used && s_hz[0]) || (rs2_used && s_hz[1]);
    assign rs1_val = reset ? rs1_rf : s_fwd[0];
    assign rs2_val = reset ? rs2_rf : s_fwd[1];
`else
    assign stall_c = (rs1_used && s_any[0]) || (rs2_used && s_any[1]);
    assign rs1_val = rs1_rf;
    assign rs2_val = rs2_rf;
`endif

    assign stall = ~reset & stall_c;

    always_comb begin
        any_valid = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            any_valid = any_valid | st[k].valid;
        end
    end

    always_comb begin
        nxt[1] = '0;
        if (ex_valid && !stall) begin
            nxt[1] = '{valid: 1'b1, regwrite: ex_regwrite, rd: ex_rd, data: ex_data, late: ex_late};
        end
        for (int k = 2; k <= DEPTH; k++) begin
            nxt[k] = st[k-1];
            // Leaving the load stage, the late result is folded into data.
            if (k - 1 == LD_STAGE) begin
                nxt[k].data = eff[k-1];
                nxt[k].late = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                st[k] <= '0;
            end
            empty_ack <= 1'b0;
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                st[k] <= nxt[k];
            end
            empty_ack <= empty_req & ~any_valid;
        end
    end

    assign wb_en   = ~reset & st[DEPTH].valid & st[DEPTH].regwrite & (st[DEPTH].rd != '0);
    assign wb_idx  = reset ? '0 : st[DEPTH].rd;
    assign wb_data = reset ? '0 : eff[DEPTH];

endmodule

// File: tb/tb_cpu7_wbpipe.sv
// Bench for cpu7_wbpipe (DEPTH=3, LD_STAGE=2): directed hazards, drain and reset, with a commit scoreboard.
module tb_cpu7_wbpipe;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam logic [31:0] LATE_VAL = 32'hCAFE_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic            ex_valid, ex_regwrite, ex_late;
    logic [RW-1:0]   ex_rd, rs1idx, rs2idx;
    logic [XLEN-1:0] ex_data, late_data, rs1_rf, rs2_rf;
    logic            rs1_used, rs2_used;
    logic [XLEN-1:0] rs1_val, rs2_val, wb_data;
    logic            stall, wb_en, empty_req, empty_ack;
    logic [RW-1:0]   wb_idx;
    logic [1:0]      ld_hist;

    typedef struct { logic [RW-1:0] idx; logic [XLEN-1:0] data; } wb_t;
    wb_t sb [$];

    int n_checks = 0;
    int n_fail   = 0;

    cpu7_wbpipe #(.XLEN(XLEN), .RFIDX_W(RW), .DEPTH(3), .LD_STAGE(2)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_rd(ex_rd), .ex_data(ex_data), .ex_late(ex_late), .late_data(late_data),
        .rs1idx(rs1idx), .rs2idx(rs2idx), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_rf(rs1_rf), .rs2_rf(rs2_rf), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .stall(stall), .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
        .empty_req(empty_req), .empty_ack(empty_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Load data is presented while the accepted load sits in stage 2.
    assign late_data = ld_hist[1] ? LATE_VAL : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (reset) begin
            ld_hist <= '0;
        end else begin
            ld_hist <= {ld_hist[0], ex_valid && !stall && ex_late};
            if (ex_valid && !stall && ex_regwrite && ex_rd != '0)
                sb.push_back('{idx: ex_rd, data: ex_late ? LATE_VAL : ex_data});
        end
    end

    always @(negedge clk) begin
        if (wb_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", {27'd0, wb_idx}, 32'hFFFF_FFFF);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_idx", {27'd0, wb_idx}, {27'd0, e.idx});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic idle();
        ex_valid = 0; ex_regwrite = 0; ex_late = 0; ex_rd = '0; ex_data = '0;
        rs1_used = 0; rs2_used = 0; rs1idx = '0; rs2idx = '0;
    endtask

    task automatic issue(input logic [RW-1:0] rd, input logic [31:0] d, input logic late);
        idle();
        ex_valid = 1; ex_regwrite = 1; ex_rd = rd; ex_data = d; ex_late = late;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic set_reader(input logic [RW-1:0] i1, input logic u1, input logic [31:0] rf1,
                              input logic [RW-1:0] i2, input logic u2, input logic [31:0] rf2);
        ex_valid = 1; ex_regwrite = 0; ex_late = 0;
        rs1idx = i1; rs1_used = u1; rs1_rf = rf1;
        rs2idx = i2; rs2_used = u2; rs2_rf = rf2;
    endtask

    task automatic reader(input string tag, input int n_stall, input int src, input logic [31:0] exp_val);
        for (int i = 0; i < n_stall; i++) begin
            @(negedge clk);
            chk({tag, "_stall_hi"}, {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, "_stall_lo"}, {31'd0, stall}, 32'd0);
        chk({tag, "_val"}, (src == 1) ? rs1_val : rs2_val, exp_val);
        @(posedge clk); #1;
        idle();
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; empty_req = 0; idle();
        rs1_rf = 32'h1234; rs2_rf = 32'h5678;
        #3;
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_wb_idx", {27'd0, wb_idx}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ack", {31'd0, empty_ack}, 32'd0);
        chk("rst_rs1", rs1_val, 32'h1234);
        chk("rst_rs2", rs2_val, 32'h5678);
        repeat (2) @(posedge clk);
        #1 reset = 0;

`ifdef CPU7_WBPIPE_FWD_EN
        issue(5, 32'h11, 0); set_reader(5, 1, 32'h99, 0, 0, 0); reader("alu_fwd", 0, 1, 32'h11);
        issue(6, 32'h0, 1);  set_reader(0, 0, 0, 6, 1, 32'h66); reader("load_use", 1, 2, LATE_VAL);
        issue(4, 32'h0, 1); @(posedge clk); #1;
        set_reader(4, 1, 32'h44, 0, 0, 0); reader("load_st2", 0, 1, LATE_VAL);
        issue(7, 32'h1, 0); issue(7, 32'h2, 0);
        set_reader(7, 1, 32'h70, 0, 0, 0); reader("b2b", 0, 1, 32'h2);
        issue(9, 32'h99, 0); set_reader(9, 0, 32'h90, 9, 0, 32'h90); reader("unused", 0, 1, 32'h99);
`else
        issue(8, 32'h88, 0); set_reader(8, 1, 32'h77, 0, 0, 0); reader("nofwd_alu", 3, 1, 32'h77);
        issue(6, 32'h0, 1);  set_reader(0, 0, 0, 6, 1, 32'h66); reader("nofwd_load", 3, 2, 32'h66);
        issue(4, 32'h0, 1); @(posedge clk); #1;
        set_reader(4, 1, 32'h44, 0, 0, 0); reader("nofwd_st2", 2, 1, 32'h44);
        issue(7, 32'h1, 0); issue(7, 32'h2, 0);
        set_reader(7, 1, 32'h70, 0, 0, 0); reader("nofwd_b2b", 3, 1, 32'h70);
        issue(9, 32'h99, 0); set_reader(9, 0, 32'h90, 9, 0, 32'h90); reader("unused", 0, 1, 32'h90);
`endif
        issue(0, 32'h55, 0); set_reader(0, 1, 32'h0, 0, 0, 0); reader("x0", 0, 1, 32'h0);

        // Drain handshake with three entries in flight.
        issue(1, 32'hA1, 0); issue(2, 32'hA2, 0); issue(3, 32'hA3, 0);
        empty_req = 1;
        @(negedge clk);
        chk("wb_latency_en", {31'd0, wb_en}, 32'd1);
        chk("wb_latency_idx", {27'd0, wb_idx}, 32'd1);
        chk("ack_full", {31'd0, empty_ack}, 32'd0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("ack_early", {31'd0, empty_ack}, 32'd0);
        end
        @(posedge clk); @(negedge clk);
        chk("ack_set", {31'd0, empty_ack}, 32'd1);
        empty_req = 0;
        @(posedge clk); @(negedge clk);
        chk("ack_clr", {31'd0, empty_ack}, 32'd0);
        @(posedge clk); #1;

        // Reset with a committing entry in the last stage.
        issue(10, 32'hB0, 0); issue(11, 32'hB1, 0); issue(12, 32'hB2, 0);
        reset = 1;
        set_reader(10, 1, 32'h321, 0, 0, 0); ex_valid = 0;
        #1;
        chk("midrst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("midrst_wb_idx", {27'd0, wb_idx}, 32'd0);
        chk("midrst_wb_data", wb_data, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_rs1", rs1_val, 32'h321);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 0; idle();
        repeat (6) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
